mod_8_counter: RTL and testbench

MOD_8_COUNTER -- requirements
Module: mod_8_counter

---
 rtl/mod_8_counter.sv | 34 +++
 tb/tb_mod_8_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mod_8_counter.sv
// Free-running modulo-8 up-counter with count enable and asynchronous active-low reset.
// Optional terminal-count flag tc is compiled in when MOD_8_COUNTER_TC_EN is defined.
module mod_8_counter #(
    localparam int unsigned CNT_W       = 3,
    parameter logic [CNT_W-1:0] RESET_VALUE = 3'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
`ifdef MOD_8_COUNTER_TC_EN
    output logic             tc,
`endif
    output logic [CNT_W-1:0] out
);

    logic [CNT_W-1:0] r_cnt;

    // Count register; natural 3-bit overflow provides the 7 -> 0 wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= RESET_VALUE;
        end else if (enable) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out = r_cnt;

`ifdef MOD_8_COUNTER_TC_EN
    // High when the next enabled edge wraps the count back to zero.
    assign tc = (r_cnt == {CNT_W{1'b1}}) & enable & reset;
`endif

endmodule

// File: tb/tb_mod_8_counter.sv
// Scoreboard bench for mod_8_counter: two instances (RESET_VALUE 0 and 5) share stimulus.
module tb_mod_8_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] out0;
    logic [2:0] out5;
`ifdef MOD_8_COUNTER_TC_EN
    logic       tc0;
    logic       tc5;
`endif

    int unsigned n_checks;
    int unsigned n_fails;
    logic [2:0]  m0;
    logic [2:0]  m5;
    logic [5:0]  exp_q[$];

    mod_8_counter #(.RESET_VALUE(3'd0)) u_dut0 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
`ifdef MOD_8_COUNTER_TC_EN
        .tc     (tc0),
`endif
        .out    (out0)
    );

    mod_8_counter #(.RESET_VALUE(3'd5)) u_dut5 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
`ifdef MOD_8_COUNTER_TC_EN
        .tc     (tc5),
`endif
        .out    (out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp();
        exp_q.push_back({m0, m5});
    endtask

    task automatic compare(input string tag);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s: got empty scoreboard expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "/rv0"}, out0, e[5:3]);
            check_val({tag, "/rv5"}, out5, e[2:0]);
        end
`ifdef MOD_8_COUNTER_TC_EN
        check_val({tag, "/tc0"}, 3'(tc0), 3'((m0 == 3'd7) && enable && reset));
        check_val({tag, "/tc5"}, 3'(tc5), 3'((m5 == 3'd7) && enable && reset));
`endif
    endtask

    // Drive enable, advance one edge, update the reference model, then compare.
    task automatic step(input logic en, input string tag);
        enable = en;
        @(posedge clk);
        if (!reset) begin
            m0 = 3'd0;
            m5 = 3'd5;
        end else if (en) begin
            m0 = 3'(m0 + 3'd1);
            m5 = 3'(m5 + 3'd1);
        end
        push_exp();
        #1 compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        m0       = 3'd0;
        m5       = 3'd5;

        // Power-up with reset asserted and enable high.
        #1 reset = 1'b0;
        #1;
        push_exp();
        compare("por_async");
        step(1'b1, "por_hold");
        step(1'b1, "por_hold");

        // Release and count through the wrap.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, "count");

        // Advance to 5, hold for three edges, then resume.
        for (int i = 0; i < 3; i++) step(1'b1, "to5");
        for (int i = 0; i < 3; i++) step(1'b0, "hold");
        step(1'b1, "resume");

        // Advance to 3, then assert reset between edges.
        for (int i = 0; i < 5; i++) step(1'b1, "to3");
        #2 reset = 1'b0;
        m0 = 3'd0;
        m5 = 3'd5;
        #2;
        push_exp();
        compare("async_rst");
        step(1'b0, "rst_en_drop");
        step(1'b0, "rst_en_drop");
        step(1'b1, "rst_hold");

        // Release with enable low: no movement until enabled.
        reset = 1'b1;
        step(1'b0, "rel_idle");
        step(1'b1, "rel_first");

        // Advance to 7, check hold at the terminal value, then reset at an edge.
        for (int i = 0; i < 6; i++) step(1'b1, "to7");
        step(1'b0, "hold7");
        enable = 1'b1;
        #1;
        push_exp();
        compare("at7_en");
        #6 reset = 1'b0;
        step(1'b1, "rst_at_edge");
        reset = 1'b1;
        step(1'b0, "no_spurious");
        step(1'b0, "no_spurious");
        step(1'b1, "first_en");
        step(1'b1, "second_en");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
